// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and encodings for the hazard/stall controller: FSM states,
// forward-select codes, the in-flight writer scoreboard entry and its NOP value.
package hazard_stall_controller_pkg;

   localparam int SB_ADDR_W = 5;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } state_e;

   localparam logic [1:0] FWD_RF    = 2'd0;
   localparam logic [1:0] FWD_EXMEM = 2'd1;
   localparam logic [1:0] FWD_MEMWB = 2'd2;

   typedef struct packed {
      logic                 valid;
      logic [SB_ADDR_W-1:0] dest;
      logic                 regwrite;
      logic                 memread;
   } sb_entry_t;

   // A bubble carries no writer: every control bit cleared.
   localparam sb_entry_t SB_NOP = '0;

   function automatic sb_entry_t make_entry(input logic [SB_ADDR_W-1:0] dest,
                                            input logic                 regwrite,
                                            input logic                 memread);
      sb_entry_t e;
      e.valid    = 1'b1;
      e.dest     = dest;
      e.regwrite = regwrite;
      e.memread  = memread;
      return e;
   endfunction

endpackage

// File: rtl/hazard_stall_controller_sb_match.sv
// One source specifier compared against one scoreboard entry. Register $0 is
// hard-wired to zero, so a write to it never produces a dependency.
module hazard_stall_controller_sb_match
   import hazard_stall_controller_pkg::*;
(
   input  sb_entry_t            entry,
   input  logic [SB_ADDR_W-1:0] src,
   input  logic                 uses,
   output logic                 match
);

   assign match = entry.valid & entry.regwrite & (|entry.dest) &
                  (entry.dest == src) & uses;

endmodule

// File: rtl/hazard_stall_controller.sv
// Decode-side pipeline sequencer: EX/MEM/WB writer scoreboard, stall/bubble/flush
// generation, stall FSM and counters. Define HAZARD_FORWARDING_EN to enable bypassing.
module hazard_stall_controller
   import hazard_stall_controller_pkg::*;
#(
   parameter int REG_ADDR_W = SB_ADDR_W,
   parameter int CNT_W      = 32,
   parameter int MAX_STALL  = 3
)
(
   input  logic                  Clock,
   input  logic                  Reset_n,
   input  logic                  Valid_ID,
   input  logic [REG_ADDR_W-1:0] Rs_ID,
   input  logic [REG_ADDR_W-1:0] Rt_ID,
   input  logic                  UsesRs_ID,
   input  logic                  UsesRt_ID,
   input  logic [REG_ADDR_W-1:0] Dest_ID,
   input  logic                  RegWrite_ID,
   input  logic                  MemRead_ID,
   input  logic                  BranchTaken_EX,
   output logic                  Stall,
   output logic                  Bubble,
   output logic                  Flush_IFID,
   output logic [1:0]            ForwardA,
   output logic [1:0]            ForwardB,
   output logic [CNT_W-1:0]      StallCount,
   output logic                  Stall_Err,
   output state_e                dbg_state,
   output sb_entry_t             dbg_wb
);

   localparam int RUN_W = $clog2(MAX_STALL + 2) + 1;

   sb_entry_t        ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   state_e           state_q, state_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic ex_a, ex_b, mem_a, mem_b;
   logic hazard;

   hazard_stall_controller_sb_match u_ex_a  (.entry(ex_q),  .src(Rs_ID), .uses(UsesRs_ID), .match(ex_a));
   hazard_stall_controller_sb_match u_ex_b  (.entry(ex_q),  .src(Rt_ID), .uses(UsesRt_ID), .match(ex_b));
   hazard_stall_controller_sb_match u_mem_a (.entry(mem_q), .src(Rs_ID), .uses(UsesRs_ID), .match(mem_a));
   hazard_stall_controller_sb_match u_mem_b (.entry(mem_q), .src(Rt_ID), .uses(UsesRt_ID), .match(mem_b));

   // The WB writer is never compared: the register file writes before it reads.
`ifdef HAZARD_FORWARDING_EN
   assign hazard = Valid_ID & ex_q.memread & (ex_a | ex_b);

   always_comb begin
      ForwardA = FWD_RF;
      ForwardB = FWD_RF;
      if (Reset_n && Valid_ID) begin
         if (ex_a)       ForwardA = FWD_EXMEM;
         else if (mem_a) ForwardA = FWD_MEMWB;
         if (ex_b)       ForwardB = FWD_EXMEM;
         else if (mem_b) ForwardB = FWD_MEMWB;
      end
   end
`else
   assign hazard   = Valid_ID & (ex_a | ex_b | mem_a | mem_b);
   assign ForwardA = FWD_RF;
   assign ForwardB = FWD_RF;
`endif

   // Handshake: Valid_ID is the ID instruction's valid, !Stall its ready; it
   // leaves ID on a clock edge only when Valid_ID & !Bubble, otherwise EX gets a NOP.
   // A taken branch wins over a stall because the ID instruction is wrong-path.
   assign Stall      = Reset_n & hazard & ~BranchTaken_EX;
   assign Bubble     = Reset_n & (Stall | BranchTaken_EX);
   assign Flush_IFID = Reset_n & BranchTaken_EX;

   always_comb begin
      ex_d = SB_NOP;
      if (Valid_ID && !Bubble) ex_d = make_entry(Dest_ID, RegWrite_ID, MemRead_ID);
      mem_d = ex_q;
      wb_d  = mem_q;
   end

   always_comb begin
      state_d = state_q;
      run_d   = '0;
      case (state_q)
         ST_RUN: begin
            if (Stall) begin
               state_d = ST_STALL;
               run_d   = RUN_W'(1);
            end
         end
         ST_STALL: begin
            if (Stall) begin
               run_d = (run_q == '1) ? run_q : run_q + RUN_W'(1);
            end else begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      err_d = err_q | (run_d > RUN_W'(MAX_STALL));
      cnt_d = cnt_q;
      if (Stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         ex_q    <= SB_NOP;
         mem_q   <= SB_NOP;
         wb_q    <= SB_NOP;
         state_q <= ST_RUN;
         run_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         wb_q    <= wb_d;
         state_q <= state_d;
         run_q   <= run_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign StallCount = cnt_q;
   assign Stall_Err  = err_q;
   assign dbg_state  = state_q;
   assign dbg_wb     = wb_q;

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencer for the 5-stage datapath (IF, ID, EX, MEM, WB). Sits beside the decode stage.
- Keeps a 3-entry destination scoreboard (EX/MEM/WB) of in-flight writers. Compares it against the source registers of the instruction currently in ID.
- Drives PC/IF-ID hold, ID/EX bubble insertion and the IF/ID flush on a taken branch. Keeps a stall-cycle performance counter.

Parameters:
- REG_ADDR_W, 5, register-specifier width
- CNT_W, 32, width of the stall counter (saturating)
- MAX_STALL, 3, consecutive stall cycles before Stall_Err is flagged

Ports:
- Clock  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- Valid_ID  in  1  ID holds a real instruction
- Rs_ID  in  5  rs specifier after the rs mux
- Rt_ID  in  5  rt specifier after the rt mux
- UsesRs_ID  in  1  ID reads rs
- UsesRt_ID  in  1  ID reads rt
- Dest_ID  in  5  destination selected for the ID instruction (after RegDst)
- RegWrite_ID  in  1  ID instruction writes the register file
- MemRead_ID  in  1  ID instruction is a load (R_Enable)
- BranchTaken_EX  in  1  EX resolved a taken branch or jump this cycle
- Stall  out  1  hold PC and IF/ID
- Bubble  out  1  load a NOP (all control 0) into ID/EX
- Flush_IFID  out  1  clear IF/ID
- ForwardA  out  2  rs forward select: 0=RF, 1=EX/MEM, 2=MEM/WB
- ForwardB  out  2  rt forward select, same encoding
- StallCount  out  CNT_W  total stalled cycles
- Stall_Err  out  1  sticky; stall run exceeded MAX_STALL

Behaviour:
- Clock/reset: one clock, Clock. Reset_n is asynchronous and active-low.
- Reset values:
  - all scoreboard entries invalid; state=RUN; StallCount=0; Stall_Err=0; run counter=0.
  - With Valid_ID=0: Stall=Bubble=Flush_IFID=0 and ForwardA=ForwardB=0.
- Scoreboard entry: {valid, dest, regwrite, memread}. An entry matches a source when valid & regwrite & dest!=0 & dest==src & the matching Uses* bit is set.
- Shift on every clock edge:
  - WB<=MEM and MEM<=EX.
  - EX<=ID fields when Valid_ID & !Bubble; otherwise EX<=invalid.
- Register file writes before it reads in the same cycle, so a WB-stage match is never a hazard.
- Hazard (no forwarding): Valid_ID and the ID sources match EX or MEM.
- Outputs:
  - Stall = hazard & !BranchTaken_EX.
  - Bubble = Stall | BranchTaken_EX.
  - Flush_IFID = BranchTaken_EX.
  - All three are combinational from registered state plus same-cycle inputs. Latency 0.
- Simultaneous events: a taken branch in EX overrides a stall. The ID instruction is wrong-path, so it is bubbled, not held.
- FSM with two states:
  - RUN->STALL when Stall=1.
  - STALL stays in STALL while Stall=1; the run counter increments each cycle.
  - STALL->RUN when Stall=0; the run counter clears.
  - Stall_Err sets when the run counter reaches MAX_STALL+1. It is cleared only by reset.
- StallCount: +1 on every edge where Stall=1. Saturates at all-ones with no wrap.
- Reset mid-stall: all state clears asynchronously. Stall deasserts immediately.

Optional Feature:
- Macro: HAZARD_FORWARDING_EN.
- Defined:
  - A hazard is only load-use: EX entry memread & match. The resulting stall is exactly 1 cycle.
  - ForwardA/ForwardB = 1 on an EX match, else 2 on a MEM match, else 0. Priority is EX > MEM; dest 0 is never forwarded.
- Undefined:
  - EX/MEM matches stall until the producer reaches WB (up to 2 cycles).
  - ForwardA/ForwardB are tied to 0.

Decomposition:
- Shared package:
  - FSM state encodings (RUN, STALL)
  - forward select encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB)
  - scoreboard entry typedef
  - NOP control constant
- One sub-module, sb_match: one source versus one entry, giving a match bit. It is instantiated per source per stage.

Test Plan:
- Reset: hold Reset_n=0 with random inputs -> all outputs 0 and StallCount=0. Release -> no stall on an independent instruction stream.
- Without the macro: add $3 followed by a read of $3 -> Stall=1 for exactly 2 cycles, Bubble=1 for both, StallCount=2, then normal progress.
- With HAZARD_FORWARDING_EN: lw $4 followed by add reading $4 -> 1-cycle stall. Next cycle ForwardA=2. Non-load producer -> ForwardA=1 with no stall.
- Write to $0 followed by a read of $0 -> no stall and Forward=0.
- Load-use hazard in the same cycle as BranchTaken_EX=1 -> Stall=0, Bubble=1, Flush_IFID=1. The next cycle has no stale hazard.
- Force MAX_STALL=1 without the macro on a 2-cycle hazard -> Stall_Err=1 and it stays set. Assert Reset_n=0 mid-stall -> Stall drops immediately and Stall_Err=0.
